// File: rtl/count_pkg.sv
// Shared types and constants for the reaction-time count sequencer and the
// CountConverter instantiation site.
package count_pkg;

  // Width of the raw count handed to CountConverter.
  localparam int CNT_W = 16;

  // Default round constants; the converter must be built with the same TARGET.
  localparam logic [CNT_W-1:0] DEF_TARGET  = 16'd5;
  localparam logic [CNT_W-1:0] DEF_TIMEOUT = 16'd15;

  // Round sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // True once the count has gone past the target value.
  function automatic logic is_after_target(input logic [CNT_W-1:0] count,
                                           input logic [CNT_W-1:0] target);
    return (count > target);
  endfunction

endpackage

// File: rtl/count_sequencer_tick_prescaler.sv
// Divides the system clock down to one tick every TICK_DIV cycles while
// enabled. The divider sits at 0 whenever it is cleared or disabled, so a
// fresh round always sees its first tick TICK_DIV cycles after it starts.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] div_cnt;

  // Tick is asserted during the cycle the divider sits at its last value.
  assign tick = enable && (div_cnt == LAST);

  // Divider register: held at 0 unless enabled, wraps after LAST.
  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Reaction-time round sequencer. A start pulse arms a round, a prescaled tick
// advances the raw count from 0, and a stop pulse or reaching TIMEOUT freezes
// the count and latches it into result_o.
//
// start_i and stop_i are single-cycle pulses from the debouncers; they carry
// no ready/acknowledge and are acted on only in the states where they matter
// (start in IDLE/HOLD, stop in RUN), being silently dropped elsewhere.
module count_sequencer
  import count_pkg::*;
#(
  parameter int               TICK_DIV = 100_000_000,
  parameter logic [CNT_W-1:0] TARGET   = DEF_TARGET,
  parameter logic [CNT_W-1:0] TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  output logic [CNT_W-1:0] counttime_o,
  output logic             phase_o,
  output logic             running_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] result_o,
  output logic [1:0]       fsm_state
);

  // The tick that would carry the count onto TIMEOUT ends the round.
  localparam logic [CNT_W-1:0] LAST_STEP = TIMEOUT - 16'd1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] result;
  logic [CNT_W-1:0] result_next;
  logic             done;
  logic             done_next;
  logic             timeout;
  logic             timeout_next;
  logic             running;
  logic             pre_clear;
  logic             pre_enable;
  logic             tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (pre_clear),
    .enable (pre_enable),
    .tick   (tick)
  );

  // Prescaler only runs while a round is live.
  assign pre_enable = (state == ST_RUN);

  // Next-state and next-value logic; stop outranks a coincident tick.
  always_comb begin
    state_next   = state;
    count_next   = count;
    result_next  = result;
    done_next    = 1'b0;
    timeout_next = timeout;
    pre_clear    = 1'b0;
    case (state)
      ST_IDLE: begin
        count_next = '0;
        if (start_i) begin
          state_next   = ST_RUN;
          pre_clear    = 1'b1;
          timeout_next = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_next   = ST_HOLD;
          result_next  = count;
          done_next    = 1'b1;
          timeout_next = 1'b0;
        end else if (tick) begin
          if (count == LAST_STEP) begin
            state_next   = ST_HOLD;
            count_next   = TIMEOUT;
            result_next  = TIMEOUT;
            done_next    = 1'b1;
            timeout_next = 1'b1;
          end else begin
            count_next = count + 16'd1;
          end
        end
      end
      ST_HOLD: begin
        if (start_i) begin
          state_next   = ST_RUN;
          count_next   = '0;
          pre_clear    = 1'b1;
          timeout_next = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // State, count and round-result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      result  <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      result  <= result_next;
      done    <= done_next;
      timeout <= timeout_next;
      running <= (state_next == ST_RUN);
    end
  end

  assign counttime_o = count;
  assign phase_o     = is_after_target(count, TARGET);
  assign running_o   = running;
  assign done_o      = done;
  assign timeout_o   = timeout;
  assign result_o    = result;
  assign fsm_state   = state;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with TICK_DIV=4, TARGET=5, TIMEOUT=15.
// A cycle-level model derives every output from elapsed time in the round.
module tb_count_sequencer;

  localparam int TD  = 4;
  localparam int TGT = 5;
  localparam int TMO = 15;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        stop_i;
  logic [15:0] counttime_o;
  logic        phase_o;
  logic        running_o;
  logic        done_o;
  logic        timeout_o;
  logic [15:0] result_o;
  logic [1:0]  fsm_state;

  int tests;
  int fails;
  bit chk_en;

  // Model of the round, advanced once per rising edge.
  bit m_running;
  int m_elapsed;
  int m_count;
  bit m_done;
  bit m_timeout;
  int m_result;

  count_sequencer #(
    .TICK_DIV (TD),
    .TARGET   (16'd5),
    .TIMEOUT  (16'd15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .counttime_o (counttime_o),
    .phase_o     (phase_o),
    .running_o   (running_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o),
    .result_o    (result_o),
    .fsm_state   (fsm_state)
  );

  // Clock and reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: count is elapsed cycles in the round divided by TD.
  always @(posedge clk) begin
    if (rst) begin
      m_running = 1'b0;
      m_elapsed = 0;
      m_count   = 0;
      m_done    = 1'b0;
      m_timeout = 1'b0;
      m_result  = 0;
    end else begin
      m_done = 1'b0;
      if (m_running) begin
        if (stop_i) begin
          m_running = 1'b0;
          m_result  = m_count;
          m_done    = 1'b1;
          m_timeout = 1'b0;
        end else begin
          m_elapsed++;
          if (m_elapsed % TD == 0) begin
            m_count = m_elapsed / TD;
            if (m_count == TMO) begin
              m_running = 1'b0;
              m_result  = m_count;
              m_done    = 1'b1;
              m_timeout = 1'b1;
            end
          end
        end
      end else if (start_i) begin
        m_running = 1'b1;
        m_elapsed = 0;
        m_count   = 0;
        m_timeout = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 32'(counttime_o), 32'(m_count));
      check("phase", 32'(phase_o), 32'(m_count > TGT));
      check("running", 32'(running_o), 32'(m_running));
      check("done", 32'(done_o), 32'(m_done));
      check("timeout", 32'(timeout_o), 32'(m_timeout));
      check("result", 32'(result_o), 32'(m_result));
    end
  end

  // Driver tasks: all land 1 time unit after a rising edge.
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    @(posedge clk);
    #1;
    stop_i = 1'b0;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    chk_en  = 1'b0;
    rst     = 1'b1;
    start_i = 1'b0;
    stop_i  = 1'b0;

    // Reset then idle, with a stray stop.
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_count", 32'(counttime_o), 0);
    check("rst_result", 32'(result_o), 0);
    check("rst_state", 32'(fsm_state), 0);
    wait_cycles(10);
    pulse_stop();
    check("idle_stop_done", 32'(done_o), 0);
    check("idle_stop_state", 32'(fsm_state), 0);
    wait_cycles(9);

    // Normal stop: stop sampled 22 edges after RUN entry.
    pulse_start();
    check("run_state", 32'(fsm_state), 1);
    check("run_running", 32'(running_o), 1);
    wait_cycles(21);
    pulse_stop();
    check("stop_result", 32'(result_o), 5);
    check("stop_done", 32'(done_o), 1);
    check("stop_phase", 32'(phase_o), 0);
    check("stop_running", 32'(running_o), 0);
    check("stop_state", 32'(fsm_state), 2);
    wait_cycles(1);
    check("stop_done_once", 32'(done_o), 0);
    wait_cycles(3);

    // Stop on the very cycle a tick would move 6 to 7.
    pulse_start();
    wait_cycles(27);
    check("pre_tick_count", 32'(counttime_o), 6);
    pulse_stop();
    check("tick_stop_result", 32'(result_o), 6);
    check("tick_stop_count", 32'(counttime_o), 6);
    check("tick_stop_phase", 32'(phase_o), 1);
    wait_cycles(3);

    // Timeout: count steps every TD cycles up to 15.
    pulse_start();
    for (int k = 1; k <= TMO; k++) begin
      wait_cycles(TD);
      check("timeout_step", 32'(counttime_o), 32'(k));
    end
    check("timeout_done", 32'(done_o), 1);
    check("timeout_flag", 32'(timeout_o), 1);
    check("timeout_result", 32'(result_o), 15);
    check("timeout_running", 32'(running_o), 0);
    wait_cycles(2);
    pulse_stop();
    check("hold_stop_result", 32'(result_o), 15);
    check("hold_stop_flag", 32'(timeout_o), 1);
    check("hold_stop_done", 32'(done_o), 0);
    wait_cycles(3);

    // Restart from HOLD, then stop at count 3.
    pulse_start();
    check("restart_count", 32'(counttime_o), 0);
    check("restart_flag", 32'(timeout_o), 0);
    check("restart_result", 32'(result_o), 15);
    wait_cycles(12);
    pulse_stop();
    check("restart_stop_result", 32'(result_o), 3);
    wait_cycles(3);

    // Reset mid-round at count 8.
    pulse_start();
    wait_cycles(33);
    check("mid_count", 32'(counttime_o), 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_count", 32'(counttime_o), 0);
    check("mid_rst_result", 32'(result_o), 0);
    check("mid_rst_done", 32'(done_o), 0);
    check("mid_rst_state", 32'(fsm_state), 0);
    wait_cycles(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Sequences the raw count fed to CountConverter for a reaction-time round. Start arms a round; a prescaled tick advances a 16-bit count from 0. Stop or a timeout freezes the count and latches the result.
- Sits between the button debouncers and CountConverter. counttime_o drives CountConverter.counttime_i directly. phase_o tells display logic whether the converter output is "before target" or "after target".

Parameters:
- TICK_DIV, 100_000_000: clk cycles per count step, ≥2.
- TARGET, 16'd5: count value the player aims to stop on; must match the converter's constant.
- TIMEOUT, 16'd15: count at which a round ends automatically; must be > TARGET.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle debounced start pulse.
- stop_i  in  1  one-cycle debounced stop pulse.
- counttime_o  out  16  live raw count, to CountConverter.
- phase_o  out  1  1 when counttime_o > TARGET, 0 otherwise; combinational from counttime_o.
- running_o  out  1  1 while in RUN.
- done_o  out  1  one-cycle pulse when a round ends.
- timeout_o  out  1  1 if the last round ended by timeout; held until the next start.
- result_o  out  16  count latched at end of round.

Behaviour:
- Reset values: state IDLE, prescaler 0, counttime_o 0, running_o 0, done_o 0, timeout_o 0, result_o 0.
- rst is synchronous: asserting it mid-round returns every register to its reset value on the next edge. No done_o is generated and result_o is cleared.
- States: IDLE, RUN, HOLD.
- IDLE:
  - counttime_o held at 0.
  - start_i → RUN next cycle, with count=0, prescaler=0, timeout_o=0.
  - stop_i is ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. In the cycle it equals TICK_DIV-1 it wraps to 0 and count increments by 1.
  - The first increment is therefore visible TICK_DIV cycles after the RUN entry edge.
  - stop_i → HOLD next cycle:
    - result_o ← the current count, pre-increment. Stop takes priority over a coincident tick, so no increment occurs.
    - done_o=1 for exactly that one cycle; timeout_o=0.
  - When a tick would take count to TIMEOUT:
    - count becomes TIMEOUT and the state goes to HOLD.
    - result_o ← TIMEOUT, done_o pulses, timeout_o ← 1.
  - Stop and the timeout tick in the same cycle: stop wins, result_o = TIMEOUT-1, timeout_o=0.
  - start_i in RUN is ignored. Simultaneous start_i and stop_i in RUN resolves as a stop.
- HOLD:
  - count frozen; prescaler held at 0; stop_i ignored.
  - start_i → RUN with the same restart actions as from IDLE. result_o keeps its old value until the next round ends.
- running_o = (state==RUN), registered with the state.
- Count width is 16 bits with no wrap; TIMEOUT bounds it.
- phase_o boundary: 0 at count==TARGET, 1 at TARGET+1.
- Prescaler width is $clog2(TICK_DIV).

Decomposition:
- Package count_pkg holds:
  - the state enum (IDLE, RUN, HOLD),
  - CNT_W=16,
  - default TARGET and TIMEOUT constants, shared with CountConverter's instantiation site.
- One natural sub-module: tick_prescaler.
  - Inputs: clk, rst, clear, enable. Output: tick pulse. Parameter: TICK_DIV.
  - count_sequencer drives clear on RUN entry and enable while in RUN.
- FSM, count and result registers stay in count_sequencer.

Test Plan (TICK_DIV=4, TARGET=5, TIMEOUT=15 for simulation):
- Reset then idle: rst high 2 cycles, then 20 idle cycles. All outputs 0; stop_i pulse in IDLE → no state change, done_o stays 0.
- Normal stop: start_i pulse, then stop_i 22 cycles after RUN entry (5 ticks elapsed). Checks:
  - result_o=5, done_o high exactly 1 cycle, phase_o=0, timeout_o=0, running_o falls with HOLD entry.
- Stop coincident with tick:
  - stop_i asserted on the cycle the prescaler is 3 with count=6 → result_o=6, not 7, and phase_o=1.
- Timeout: start_i, no stop. Checks:
  - counttime_o steps 0..15 every 4 cycles.
  - At 15: HOLD, done_o pulse, timeout_o=1, result_o=15.
  - A subsequent stop_i is ignored.
- Restart from HOLD: after a timeout, start_i → counttime_o=0, timeout_o=0, result_o still 15 until the next stop. Then stop at count 3 → result_o=3.
- Reset mid-round: rst at count=8 in RUN → next cycle state IDLE, counttime_o=0, result_o=0, no done_o pulse.
